core_if_fetch: RTL

- Instruction fetch unit directly upstream of the ID decode stage.
- Generates the sequential PC and issues word requests to the instruction memory port over a valid/ready handshake.
- Buffers in-order responses together with their PCs, then presents {pc, inst} to decode over a valid/ready handshake.
- Handles redirects from the branch/jump unit by flushing its state and discarding stale responses that are still in flight.

---
 rtl/core_if_fetch.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/core_if_fetch.sv
// core_if_fetch: sequential instruction fetch with an in-order response buffer and redirect flush.
// Optional CORE_IFU_BYPASS_EN forwards a response to decode in the cycle it arrives when the buffer is empty.
module core_if_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_halt,
    output logic        o_ifu_req_valid,
    output logic [31:0] o_ifu_req_addr,
    input  logic        i_ifu_req_ready,
    input  logic        i_ifu_rsp_valid,
    input  logic [31:0] i_ifu_rsp_inst,
    input  logic        i_ifu_rsp_err,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_inst_err,
    input  logic        i_inst_ready
);
    // state    | meaning
    // RUN      | issuing sequential requests while credit remains
    // HALT     | no new requests; in-flight responses still buffered and drained
    // ERR_WAIT | a fetch error was taken; no requests until a redirect
    typedef enum logic [1:0] {RUN, HALT, ERR_WAIT} state_t;

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    state_t                 state;
    logic [31:0]            pc;
    logic [CW-1:0]          outstanding;
    logic [CW-1:0]          drop_cnt;
    logic [CW-1:0]          buf_count;
    logic [31:0]            pcq [BUF_DEPTH];
    logic [PW-1:0]          pcq_wr;
    logic [PW-1:0]          pcq_rd;
    logic [31:0]            buf_pc [BUF_DEPTH];
    logic [31:0]            buf_inst [BUF_DEPTH];
    logic [BUF_DEPTH-1:0]   buf_err;
    logic [PW-1:0]          buf_wr;
    logic [PW-1:0]          buf_rd;

    logic req_fire;
    logic rsp_take;
    logic err_in;
    logic buf_empty;
    logic buf_push;
    logic buf_pop;
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

    assign buf_empty       = (buf_count == '0);
    assign o_ifu_req_valid = ~rst & (state == RUN) & ~i_redirect_valid &
                             (({1'b0, outstanding} + {1'b0, buf_count}) < {1'b0, DEPTH_C});
    assign o_ifu_req_addr  = pc;
    assign req_fire        = o_ifu_req_valid & i_ifu_req_ready;
    // Responses during a redirect or while stale requests remain are never taken.
    assign rsp_take        = i_ifu_rsp_valid & (drop_cnt == '0) & ~i_redirect_valid;
    assign err_in          = rsp_take & i_ifu_rsp_err;

`ifdef CORE_IFU_BYPASS_EN
    logic byp;
    assign byp          = rsp_take & buf_empty;
    assign o_inst_valid = ~i_redirect_valid & (byp | ~buf_empty);
    assign o_inst       = byp ? i_ifu_rsp_inst : buf_inst[buf_rd];
    assign o_inst_pc    = byp ? pcq[pcq_rd]    : buf_pc[buf_rd];
    assign o_inst_err   = byp ? i_ifu_rsp_err  : buf_err[buf_rd];
    assign buf_push     = rsp_take & ~(byp & i_inst_ready);
`else
    assign o_inst_valid = ~buf_empty;
    assign o_inst       = buf_inst[buf_rd];
    assign o_inst_pc    = buf_pc[buf_rd];
    assign o_inst_err   = buf_err[buf_rd];
    assign buf_push     = rsp_take;
`endif
    assign buf_pop = ~buf_empty & i_inst_ready & ~i_redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            buf_count   <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
            buf_wr      <= '0;
            buf_rd      <= '0;
            buf_err     <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                pcq[i]      <= '0;
                buf_pc[i]   <= '0;
                buf_inst[i] <= '0;
            end
        end else if (i_redirect_valid) begin
            // Every request still in flight becomes stale; a response arriving now is one of them.
            state       <= i_halt ? HALT : RUN;
            pc          <= {i_redirect_pc[31:2], 2'b00};
            outstanding <= outstanding - CW'(i_ifu_rsp_valid);
            drop_cnt    <= outstanding - CW'(i_ifu_rsp_valid);
            buf_count   <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
            buf_wr      <= '0;
            buf_rd      <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (err_in)      state <= ERR_WAIT;
                    else if (i_halt) state <= HALT;
                end
                HALT: begin
                    if (err_in)       state <= ERR_WAIT;
                    else if (!i_halt) state <= RUN;
                end
                default: state <= state;
            endcase
            if (req_fire) begin
                pc          <= pc + 32'd4;
                pcq[pcq_wr] <= pc;
                pcq_wr      <= pcq_wr + PW'(1);
            end
            if (rsp_take) pcq_rd <= pcq_rd + PW'(1);
            outstanding <= outstanding + CW'(req_fire) - CW'(i_ifu_rsp_valid);
            if (i_ifu_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
            if (buf_push) begin
                buf_pc[buf_wr]   <= pcq[pcq_rd];
                buf_inst[buf_wr] <= i_ifu_rsp_inst;
                buf_err[buf_wr]  <= i_ifu_rsp_err;
                buf_wr           <= buf_wr + PW'(1);
            end
            if (buf_pop) buf_rd <= buf_rd + PW'(1);
            buf_count <= buf_count + CW'(buf_push) - CW'(buf_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(buf_push && buf_count == DEPTH_C));
    end

endmodule
